// File: rtl/delay_share_arbiter.sv
// Round-robin, credit-limited arbiter sharing one fixed-latency matrix delay line.
// A {valid, owner} tag rides alongside the datapath so each output is returned to its requester.
module delay_share_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DELAY_CYCLES = 4,
  parameter int CREDITS      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              flush,
  output logic [$clog2(NUM_REQ)-1:0]        grant_sel,
  output logic                              dl_load,
  output logic [NUM_REQ-1:0]                out_valid,
  output logic [$clog2(DELAY_CYCLES+1)-1:0] occupancy,
  output logic                              busy
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int OCC_W = $clog2(DELAY_CYCLES + 1);
  localparam int CRD_W = $clog2(CREDITS + 1);
  localparam int LAST  = DELAY_CYCLES - 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("delay_share_arbiter: NUM_REQ must be 2..8");
  end
  if (DELAY_CYCLES < 1 || DELAY_CYCLES > 32) begin : g_bad_delay
    $error("delay_share_arbiter: DELAY_CYCLES must be 1..32");
  end
  if (CREDITS < 1 || CREDITS > DELAY_CYCLES) begin : g_bad_credits
    $error("delay_share_arbiter: CREDITS must be 1..DELAY_CYCLES");
  end

  logic                 r_vld_p [DELAY_CYCLES];
  logic [SEL_W-1:0]     r_tag_p [DELAY_CYCLES];
  logic [CRD_W-1:0]     r_credit [NUM_REQ];
  logic [SEL_W-1:0]     r_rr_ptr;
  logic [OCC_W-1:0]     r_occ;

  logic [NUM_REQ-1:0]   w_elig;
  logic [SEL_W:0]       w_cand;
  logic                 w_found;
  logic [SEL_W-1:0]     w_win;
  logic [SEL_W-1:0]     w_ptr_nxt;

  // Eligibility is gated by rst_n so grants vanish the moment reset asserts.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = rst_n & ~flush & req_valid[i] & (r_credit[i] < CRD_W'(CREDITS));
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_cand = {1'b0, r_rr_ptr} + (SEL_W+1)'(off);
      if (w_cand >= (SEL_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (SEL_W+1)'(NUM_REQ);
      end
      if (!w_found && w_elig[w_cand[SEL_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_found) begin
      req_ready[w_win] = 1'b1;
    end
    grant_sel = w_found ? w_win : '0;
    dl_load   = w_found;
    w_ptr_nxt = (w_win == SEL_W'(NUM_REQ - 1)) ? '0 : w_win + SEL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (flush) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  // Stage 0 captures the grant; each later stage copies its predecessor. Flush only kills valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DELAY_CYCLES; n++) begin
        r_vld_p[n] <= 1'b0;
        r_tag_p[n] <= '0;
      end
    end else begin
      r_vld_p[0] <= dl_load & ~flush;
      r_tag_p[0] <= grant_sel;
      for (int n = 1; n < DELAY_CYCLES; n++) begin
        r_vld_p[n] <= r_vld_p[n-1] & ~flush;
        r_tag_p[n] <= r_tag_p[n-1];
      end
    end
  end

  always_comb begin
    out_valid = '0;
    if (r_vld_p[LAST]) begin
      out_valid[r_tag_p[LAST]] = 1'b1;
    end
  end

  // A grant and a return for the same requester in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_credit[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_credit[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({req_ready[i], out_valid[i]})
          2'b10:   r_credit[i] <= r_credit[i] + CRD_W'(1);
          2'b01:   r_credit[i] <= r_credit[i] - CRD_W'(1);
          default: r_credit[i] <= r_credit[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      case ({dl_load, r_vld_p[LAST]})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occupancy = r_occ;
  assign busy      = (r_occ != '0);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_credit_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid[gi] |-> (r_credit[gi] != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      r_credit[gi] <= CRD_W'(CREDITS));
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: tb/tb_delay_share_arbiter.sv
// Directed and random stimulus for delay_share_arbiter (4 requesters, 3-cycle line, 2 credits),
// with a due-cycle scoreboard for returned tags and a small arbitration model.
module tb_delay_share_arbiter;

  localparam int NR = 4;
  localparam int DC = 3;
  localparam int CR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] req_valid = 4'h0;
  logic [3:0] req_ready;
  logic [1:0] grant_sel;
  logic       dl_load;
  logic [3:0] out_valid;
  logic [1:0] occupancy;
  logic       busy;

  always #5 clk = ~clk;

  delay_share_arbiter #(.NUM_REQ(NR), .DELAY_CYCLES(DC), .CREDITS(CR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .flush     (flush),
    .grant_sel (grant_sel),
    .dl_load   (dl_load),
    .out_valid (out_valid),
    .occupancy (occupancy),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0] tag;
    int         due;
  } ent_t;

  ent_t sb[$];
  int   m_ptr;
  int   m_cred [NR];
  int   cyc;
  int   n_assert;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr = 0;
    for (int i = 0; i < NR; i++) m_cred[i] = 0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 0);
    chk({pfx, "_dl_load"},   dl_load,   0);
    chk({pfx, "_grant_sel"}, grant_sel, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_occupancy"}, occupancy, 0);
    chk({pfx, "_busy"},      busy,      0);
  endtask

  // Called at a falling edge: drive, check just after, advance the model, wait for next falling edge.
  task automatic step(input logic [3:0] rv, input logic fl);
    logic [3:0] e_ov;
    logic [3:0] e_rdy;
    logic       e_found;
    logic [1:0] e_k;
    int         idx;
    int         e_occ;
    req_valid = rv;
    flush     = fl;
    #1;
    e_ov = 4'h0;
    if (sb.size() > 0 && sb[0].due == cyc) e_ov = 4'b0001 << sb[0].tag;
    e_occ   = sb.size();
    e_found = 1'b0;
    e_k     = 2'd0;
    for (int off = 0; off < NR; off++) begin
      idx = (m_ptr + off) % NR;
      if (!e_found && rv[idx] && m_cred[idx] < CR && !fl) begin
        e_found = 1'b1;
        e_k     = idx[1:0];
      end
    end
    e_rdy = e_found ? (4'b0001 << e_k) : 4'h0;
    chk("req_ready", req_ready, e_rdy);
    chk("grant_sel", grant_sel, e_k);
    chk("dl_load",   dl_load,   e_found);
    chk("out_valid", out_valid, e_ov);
    chk("occupancy", occupancy, e_occ);
    chk("busy",      busy,      e_occ != 0);
    for (int i = 0; i < NR; i++) chk("credit", dut.r_credit[i], m_cred[i]);
    if (e_ov != 4'h0) begin
      m_cred[sb[0].tag]--;
      void'(sb.pop_front());
    end
    if (e_found) begin
      sb.push_back('{tag: e_k, due: cyc + DC});
      m_cred[e_k]++;
      m_ptr = (e_k + 1) % NR;
    end
    if (fl) model_reset();
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    model_reset();

    // Reset held with every requester asking: nothing may be granted.
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, grant in first clock after release, return 3 cycles later.
    step(4'b0001, 1'b0);
    repeat (4) step(4'b0000, 1'b0);

    // All requesting: rotating grants, returns follow 3 cycles behind.
    repeat (10) step(4'b1111, 1'b0);
    repeat (4) step(4'b0000, 1'b0);

    // Credit limit on a lone requester.
    repeat (9) step(4'b0001, 1'b0);
    repeat (4) step(4'b0000, 1'b0);

    // Flush with two tags in flight, then the pointer must restart at requester 0.
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b1111, 1'b1);
    repeat (5) step(4'b1110, 1'b0);
    repeat (2) step(4'b1111, 1'b0);
    repeat (4) step(4'b0000, 1'b0);

    // Request dropped without a transfer loses nothing.
    step(4'b0110, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    repeat (4) step(4'b0000, 1'b0);

    // Asynchronous reset with the line full.
    repeat (3) step(4'b1111, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(4'b0000, 1'b0);

    // Random traffic with occasional flushes.
    for (int n = 0; n < 300; n++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0));
    end
    for (int g = 0; g < 8; g++) step(4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
